// File: rtl/flag_ctx_reg_if.sv
// Bundles the control and status signals of the EX-stage flag register.
// The decoder/ALU side uses the master modport; the register uses slave.
interface flag_ctx_reg_if #(
  parameter int NFLAGS = 4,
  parameter int DEPTH  = 4,
  parameter int LW     = $clog2(DEPTH + 1)
);
  logic              stall;
  logic [NFLAGS-1:0] flag_in;
  logic [NFLAGS-1:0] upd_mask;
  logic              wr_en;
  logic [NFLAGS-1:0] wr_data;
  logic              push;
  logic              pop;
  logic              err_clr;
  logic [NFLAGS-1:0] flags;
  logic [LW-1:0]     level;
  logic              full;
  logic              empty;
  logic              ovf_err;
  logic              unf_err;
  logic              cfl_err;

  modport master (
    output stall, flag_in, upd_mask, wr_en, wr_data, push, pop, err_clr,
    input  flags, level, full, empty, ovf_err, unf_err, cfl_err
  );

  modport slave (
    input  stall, flag_in, upd_mask, wr_en, wr_data, push, pop, err_clr,
    output flags, level, full, empty, ovf_err, unf_err, cfl_err
  );
endinterface

// File: rtl/flag_ctx_reg.sv
// Parametrised condition-flag register with per-bit update masking, stall
// hold, direct write and a LIFO shadow stack for trap entry/return.
module flag_ctx_reg #(
  parameter int NFLAGS = 4,
  parameter int DEPTH  = 4,
  parameter int LW     = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  flag_ctx_reg_if.slave bus
);

  logic [NFLAGS-1:0] flags_q, flags_d;
  logic [LW-1:0]     level_q, level_d;
  logic [NFLAGS-1:0] stack_q [DEPTH];
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              cfl_q, cfl_d;

  logic              full, empty;
  logic              push_req, pop_req, conflict;
  logic              push_ok, pop_ok;
  logic [NFLAGS-1:0] top_flags;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);

  // A lone push or pop is a stack request; both together is a conflict and
  // suppresses the stack operation entirely.
  assign push_req = !bus.stall && bus.push && !bus.pop;
  assign pop_req  = !bus.stall && bus.pop  && !bus.push;
  assign conflict = !bus.stall && bus.push && bus.pop;
  assign push_ok  = push_req && !full;
  assign pop_ok   = pop_req  && !empty;

  // Select the top-of-stack entry (index level-1) without a narrowing index.
  always_comb begin
    top_flags = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (level_q == LW'(i + 1)) top_flags = stack_q[i];
    end
  end

  // Next-state for flags, level and the sticky error bits.
  always_comb begin
    flags_d = flags_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    cfl_d   = cfl_q;
    if (!bus.stall) begin
      if (pop_ok)          flags_d = top_flags;
      else if (bus.wr_en)  flags_d = bus.wr_data;
      else                 flags_d = (bus.flag_in & bus.upd_mask) | (flags_q & ~bus.upd_mask);

      if (push_ok)         level_d = level_q + LW'(1);
      else if (pop_ok)     level_d = level_q - LW'(1);

      // A set condition in the same cycle as err_clr leaves the bit set.
      if (bus.err_clr) begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
        cfl_d = 1'b0;
      end
      if (push_req && full)  ovf_d = 1'b1;
      if (pop_req && empty)  unf_d = 1'b1;
      if (conflict)          cfl_d = 1'b1;
    end
  end

  // State registers; stack storage is cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      cfl_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
    end else begin
      flags_q <= flags_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      cfl_q   <= cfl_d;
      // A push stores the pre-update flags at the current level.
      for (int i = 0; i < DEPTH; i++) begin
        if (push_ok && level_q == LW'(i)) stack_q[i] <= flags_q;
      end
    end
  end

  assign bus.flags   = flags_q;
  assign bus.level   = level_q;
  assign bus.full    = full;
  assign bus.empty   = empty;
  assign bus.ovf_err = ovf_q;
  assign bus.unf_err = unf_q;
  assign bus.cfl_err = cfl_q;

endmodule

// File: tb/tb_flag_ctx_reg.sv
// Self-checking bench for flag_ctx_reg (NFLAGS=4, DEPTH=4) against a
// queue-based reference model of the flag register and shadow stack.
module tb_flag_ctx_reg;
  localparam int NF = 4;
  localparam int DP = 4;
  localparam int LWT = $clog2(DP + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  flag_ctx_reg_if #(.NFLAGS(NF), .DEPTH(DP), .LW(LWT)) bus ();

  flag_ctx_reg #(.NFLAGS(NF), .DEPTH(DP), .LW(LWT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [NF-1:0] m_flags;
  logic [NF-1:0] m_stack[$];
  bit            m_ovf, m_unf, m_cfl;

  function automatic logic [12:0] got_vec();
    return {bus.flags, bus.level, bus.full, bus.empty, bus.ovf_err, bus.unf_err, bus.cfl_err};
  endfunction

  function automatic logic [12:0] exp_vec();
    return {m_flags, 3'(m_stack.size()), m_stack.size() == DP, m_stack.size() == 0,
            m_ovf, m_unf, m_cfl};
  endfunction

  task automatic model_reset();
    m_flags = '0;
    m_stack.delete();
    m_ovf = 0; m_unf = 0; m_cfl = 0;
  endtask

  // Drive one cycle of controls, advance the model, sample 1 ns after the edge.
  task automatic cycle(input bit st, input logic [NF-1:0] fin, input logic [NF-1:0] msk,
                       input bit we, input logic [NF-1:0] wd,
                       input bit ps, input bit pp, input bit ec);
    logic [NF-1:0] nf;
    bit popped, so, su, sc;
    bus.stall = st; bus.flag_in = fin; bus.upd_mask = msk; bus.wr_en = we;
    bus.wr_data = wd; bus.push = ps; bus.pop = pp; bus.err_clr = ec;
    if (!st) begin
      popped = 0; so = 0; su = 0; sc = 0; nf = m_flags;
      if (ps && pp) sc = 1;
      else if (ps) begin
        if (m_stack.size() < DP) m_stack.push_back(m_flags);
        else so = 1;
      end else if (pp) begin
        if (m_stack.size() > 0) begin nf = m_stack.pop_back(); popped = 1; end
        else su = 1;
      end
      if (!popped) begin
        if (we) nf = wd;
        else    nf = (fin & msk) | (m_flags & ~msk);
      end
      m_flags = nf;
      if (ec) begin m_ovf = so; m_unf = su; m_cfl = sc; end
      else begin m_ovf |= so; m_unf |= su; m_cfl |= sc; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(0, '0, '0, 0, '0, 0, 0, 0);
  endtask

  task automatic test_reset();
    model_reset();
    bus.stall = 0; bus.flag_in = '0; bus.upd_mask = '0; bus.wr_en = 0;
    bus.wr_data = '0; bus.push = 0; bus.pop = 0; bus.err_clr = 0;
    rst_n = 1'b0;
    #3;
    tests_run++;
    if (got_vec() !== 13'b0000_000_0_1_000) begin
      tests_failed++;
      $display("FAIL reset_state got=%b exp=%b", got_vec(), 13'b0000_000_0_1_000);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    // Build level=2, flags=1010, then reset asynchronously mid-cycle.
    cycle(0, '0, '0, 1, 4'b0011, 1, 0, 0);
    cycle(0, '0, '0, 1, 4'b1010, 1, 0, 0);
    tests_run++;
    if (got_vec() !== exp_vec() || bus.level !== 3'd2 || bus.flags !== 4'b1010) begin
      tests_failed++;
      $display("FAIL pre_reset_setup got=%b exp=%b", got_vec(), exp_vec());
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    tests_run++;
    if (got_vec() !== 13'b0000_000_0_1_000) begin
      tests_failed++;
      $display("FAIL async_reset got=%b exp=%b", got_vec(), 13'b0000_000_0_1_000);
    end
    #1 rst_n = 1'b1;
    // Stack must be cleared: a pop now underflows and leaves flags at 0.
    cycle(0, '0, '0, 0, '0, 0, 1, 0);
    tests_run++;
    if (got_vec() !== exp_vec() || bus.unf_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL post_reset_pop got=%b exp=%b", got_vec(), exp_vec());
    end
    cycle(0, '0, '0, 0, '0, 0, 0, 1);
  endtask

  task automatic test_masked_update();
    cycle(0, '0, '0, 1, 4'b0000, 0, 0, 0);
    cycle(0, 4'b1111, 4'b0101, 0, '0, 0, 0, 0);
    tests_run++;
    if (bus.flags !== 4'b0101 || got_vec() !== exp_vec()) begin
      tests_failed++;
      $display("FAIL masked_update got=%b exp=0101", bus.flags);
    end
    cycle(0, 4'b0000, 4'b0000, 0, '0, 0, 0, 0);
    tests_run++;
    if (bus.flags !== 4'b0101 || got_vec() !== exp_vec()) begin
      tests_failed++;
      $display("FAIL mask_zero_hold got=%b exp=0101", bus.flags);
    end
  endtask

  task automatic test_priority();
    cycle(0, '0, '0, 1, 4'b0011, 0, 0, 0);
    cycle(0, 4'b0111, 4'b1111, 1, 4'b1000, 0, 0, 0);
    tests_run++;
    if (bus.flags !== 4'b1000 || got_vec() !== exp_vec()) begin
      tests_failed++;
      $display("FAIL wr_over_mask got=%b exp=1000", bus.flags);
    end
    cycle(1, 4'b1111, 4'b1111, 1, 4'b0001, 1, 0, 1);
    tests_run++;
    if (bus.flags !== 4'b1000 || got_vec() !== exp_vec()) begin
      tests_failed++;
      $display("FAIL stall_hold got=%b exp=1000", bus.flags);
    end
  endtask

  task automatic test_push_pop();
    cycle(0, '0, '0, 1, 4'b0110, 0, 0, 0);
    cycle(0, 4'b1001, 4'b1111, 0, '0, 1, 0, 0);
    tests_run++;
    if (bus.flags !== 4'b1001 || bus.level !== 3'd1 || got_vec() !== exp_vec()) begin
      tests_failed++;
      $display("FAIL push_update got=%b/%0d exp=1001/1", bus.flags, bus.level);
    end
    cycle(0, '0, '0, 1, 4'b1111, 0, 1, 0);
    tests_run++;
    if (bus.flags !== 4'b0110 || bus.level !== 3'd0 || bus.empty !== 1'b1 ||
        got_vec() !== exp_vec()) begin
      tests_failed++;
      $display("FAIL pop_restore got=%b/%0d exp=0110/0", bus.flags, bus.level);
    end
  endtask

  task automatic test_boundaries();
    for (int i = 0; i < 5; i++) begin
      cycle(0, '0, '0, 1, 4'(i + 1), 1, 0, 0);
      tests_run++;
      if (got_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL push_%0d got=%b exp=%b", i, got_vec(), exp_vec());
      end
    end
    tests_run++;
    if (bus.level !== 3'd4 || bus.full !== 1'b1 || bus.ovf_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_ovf got=lvl%0d full%b ovf%b exp=lvl4 full1 ovf1",
               bus.level, bus.full, bus.ovf_err);
    end
    for (int i = 0; i < 5; i++) begin
      cycle(0, '0, '0, 0, '0, 0, 1, 0);
      tests_run++;
      if (got_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL pop_%0d got=%b exp=%b", i, got_vec(), exp_vec());
      end
    end
    tests_run++;
    if (bus.unf_err !== 1'b1 || bus.level !== 3'd0) begin
      tests_failed++;
      $display("FAIL underflow got=unf%b lvl%0d exp=unf1 lvl0", bus.unf_err, bus.level);
    end
    cycle(0, '0, '0, 0, '0, 0, 0, 1);
    tests_run++;
    if (bus.ovf_err !== 1'b0 || bus.unf_err !== 1'b0 || got_vec() !== exp_vec()) begin
      tests_failed++;
      $display("FAIL err_clr got=ovf%b unf%b exp=ovf0 unf0", bus.ovf_err, bus.unf_err);
    end
    for (int i = 0; i < 4; i++) cycle(0, '0, '0, 1, 4'(8 + i), 1, 0, 0);
    cycle(0, '0, '0, 0, '0, 1, 0, 1);
    tests_run++;
    if (bus.ovf_err !== 1'b1 || got_vec() !== exp_vec()) begin
      tests_failed++;
      $display("FAIL set_wins_clr got=ovf%b exp=ovf1", bus.ovf_err);
    end
    for (int i = 0; i < 4; i++) cycle(0, '0, '0, 0, '0, 0, 1, 0);
    cycle(0, '0, '0, 0, '0, 0, 0, 1);
  endtask

  task automatic test_conflict();
    cycle(0, '0, '0, 1, 4'b1100, 0, 0, 0);
    cycle(0, '0, '0, 1, 4'b0001, 1, 0, 0);
    cycle(0, 4'b0010, 4'b0010, 0, '0, 1, 1, 0);
    tests_run++;
    if (bus.level !== 3'd1 || bus.cfl_err !== 1'b1 || bus.flags[1] !== 1'b1 ||
        got_vec() !== exp_vec()) begin
      tests_failed++;
      $display("FAIL conflict got=lvl%0d cfl%b f%b exp=lvl1 cfl1 f=0011",
               bus.level, bus.cfl_err, bus.flags);
    end
    cycle(0, '0, '0, 0, '0, 0, 1, 0);
    tests_run++;
    if (bus.flags !== 4'b1100 || got_vec() !== exp_vec()) begin
      tests_failed++;
      $display("FAIL conflict_top got=%b exp=1100", bus.flags);
    end
    cycle(0, '0, '0, 0, '0, 0, 0, 1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 4) == 0, 4'($urandom), 4'($urandom),
            $urandom_range(0, 3) == 0, 4'($urandom),
            $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 7) == 0);
      tests_run++;
      if (got_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL random_%0d got=%b exp=%b", n, got_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_masked_update();
    test_priority();
    test_push_pop();
    test_boundaries();
    test_conflict();
    test_random();
    idle();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/flag_ctx_reg.md
Name: flag_ctx_reg

Overview:
- Parametrised condition-flag register for the EX stage; successor to the fixed three-flag N/Z/V register.
- Adds per-flag update masking, a pipeline stall hold and a direct flag-write path.
- Adds a LIFO shadow stack that saves and restores flags across interrupt/trap entry and return.
- The ALU drives the candidate flags; the decoder drives the mask, write and push/pop controls; branch logic consumes the flags output.

Parameters:
- NFLAGS, 4, number of flag bits. Default mapping: bit0=N, bit1=Z, bit2=V, bit3=C. Legal range 1..16.
- DEPTH, 4, shadow stack depth in entries. Legal range 1..16.
- LW, $clog2(DEPTH+1), width of the level output (derived; do not override).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hold all state this cycle
- flag_in  in  NFLAGS  candidate flags from the ALU
- upd_mask  in  NFLAGS  per-bit update enable for flag_in
- wr_en  in  1  direct write of all flags
- wr_data  in  NFLAGS  direct write value
- push  in  1  save the current flags to the stack
- pop  in  1  restore the flags from the stack top
- err_clr  in  1  clear the sticky error bits
- flags  out  NFLAGS  registered flags
- level  out  LW  number of occupied stack entries
- full  out  1  level==DEPTH (combinational from level)
- empty  out  1  level==0 (combinational from level)
- ovf_err  out  1  sticky: push attempted while full
- unf_err  out  1  sticky: pop attempted while empty
- cfl_err  out  1  sticky: push and pop asserted in the same cycle

Behaviour:
- Reset (async assert, sync-to-clk deassert at the source):
  - flags=0, level=0, all error bits=0.
  - Stack storage is cleared to 0.
- All state updates on the rising clk edge. flags reflects an update one cycle after the controls are sampled. No combinational path from any input to flags.
- stall=1:
  - Everything holds: flags, level, stack and error bits.
  - All other inputs are ignored, including err_clr; no error is set.
- stall=0, flags next-value priority (highest first):
  1. A legal pop: flags <= stack[level-1]. wr_en and upd_mask are ignored.
  2. wr_en=1: flags <= wr_data. upd_mask is ignored.
  3. Otherwise, for each bit i: flags[i] <= upd_mask[i] ? flag_in[i] : flags[i]. upd_mask=0 means hold.
- Push (stall=0, push=1, pop=0):
  - If not full: stack[level] <= the current flags value (pre-update value of this cycle); level+1.
  - In the same cycle, flags still updates per rules 2/3, so push-and-update is legal.
  - If full: stack and level unchanged, ovf_err <= 1. The flags update still occurs.
- Pop (stall=0, pop=1, push=0):
  - If not empty: flags <= top entry; level-1.
  - If empty: level unchanged, unf_err <= 1. flags update per rules 2/3.
- Push and pop in the same cycle (stall=0):
  - The stack operation is suppressed and level is unchanged.
  - cfl_err <= 1; flags update per rules 2/3.
- Error bits:
  - Each bit is set only by its condition and is cleared by err_clr=1 (stall=0).
  - If a set condition and err_clr occur in the same cycle, set wins.
- level saturation:
  - Never exceeds DEPTH and never goes below 0.
  - Wrap-around is forbidden; the stack is a plain LIFO indexed by level, not circular.
- NFLAGS=1 and DEPTH=1 must elaborate and behave as above.

Test Plan (NFLAGS=4, DEPTH=4):
- Reset mid-operation: with level=2 and flags=4'b1010, pulse rst_n low → flags=0, level=0, empty=1 and errors=0 immediately, without waiting for a clk edge.
- Masked update: flags=4'b0000, flag_in=4'b1111, upd_mask=4'b0101 → next flags=4'b0101. Then upd_mask=0 with flag_in=4'b0000 → flags stays 4'b0101.
- Priority: flags=4'b0011, wr_en=1, wr_data=4'b1000, upd_mask=4'b1111, flag_in=4'b0111 → flags=4'b1000. Next cycle, with stall=1 and wr_en=1, wr_data=4'b0001 → flags holds 4'b1000.
- Push/pop round trip:
  - flags=4'b0110; push with upd_mask=4'b1111, flag_in=4'b1001 → flags=4'b1001, level=1.
  - Then pop with wr_en=1, wr_data=4'b1111 → flags=4'b0110, level=0, empty=1.
- Full/empty boundaries:
  - 5 consecutive pushes → level=4, full=1, ovf_err=1 on the 5th. The 4th entry is intact: 4 pops restore it first.
  - A 5th pop → unf_err=1, level stays 0.
  - err_clr → both error bits clear. err_clr in the same cycle as an overflowing push leaves ovf_err=1.
- Conflict: level=1; push=1 and pop=1 with upd_mask=4'b0010, flag_in=4'b0010 → level=1, cfl_err=1, flags bit1=1, stack top unchanged (verified by a subsequent pop).
